// File: rtl/mem_responder.sv
// mem_responder: fixed-latency responder for the control unit's MemRead/MemWrite
// strobes. Owns a word-addressed data RAM plus one memory-mapped output
// register at IO_ADDR. Each accepted request completes with a one-cycle
// MemReady pulse; the FSM then waits in RELEASE for the request level to drop,
// so a held strobe yields exactly one transaction.
module mem_responder #(
  parameter int                DATA_W  = 16,
  parameter int                ADDR_W  = 8,
  parameter int                LATENCY = 2,
  parameter logic [ADDR_W-1:0] IO_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              MemReady,
  output logic              Busy,
  output logic [DATA_W-1:0] OutPort,
  output logic              OutValid,
  output logic              ReqError
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_RELEASE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t              r_state, w_next;
  logic [3:0]          r_cnt;
  logic                r_op_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_outport;
  logic                r_reqerr;
  logic [DATA_W-1:0]   r_mem [2**ADDR_W];

  logic w_rd_only, w_wr_only, w_both, w_access, w_io;

  assign w_rd_only = MemRead & ~MemWrite;
  assign w_wr_only = MemWrite & ~MemRead;
  assign w_both    = MemRead & MemWrite;
  // Access happens on the edge that leaves WAIT with the counter expired.
  assign w_access  = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_io      = (r_addr == IO_ADDR);

  // State register.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; RELEASE holds until both request levels are low.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_rd_only || w_wr_only) w_next = S_WAIT;
      S_WAIT:    if (r_cnt == 4'd0) w_next = S_DONE;
      S_DONE:    w_next = S_RELEASE;
      S_RELEASE: if (!MemRead && !MemWrite) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Request latch, latency counter, read data, output register, error flag.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_cnt     <= '0;
      r_op_wr   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_outport <= '0;
      r_reqerr  <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        if (w_both) begin
          r_reqerr <= 1'b1;
        end else if (w_rd_only || w_wr_only) begin
          r_op_wr <= w_wr_only;
          r_addr  <= Addr;
          r_wdata <= WriteData;
          r_cnt   <= CNT_LOAD;
        end
      end else if (r_state == S_WAIT) begin
        if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else if (!r_op_wr) begin
          r_rdata <= w_io ? r_outport : r_mem[r_addr];
        end else if (w_io) begin
          r_outport <= r_wdata;
        end
      end
    end
  end

  // RAM write port; no reset so contents survive Reset, and an abandoned
  // transaction never reaches here because reset forces the FSM to IDLE.
  always_ff @(posedge CLK) begin
    if (w_access && r_op_wr && !w_io) r_mem[r_addr] <= r_wdata;
  end

  assign ReadData = r_rdata;
  assign MemReady = (r_state == S_DONE);
  assign OutValid = (r_state == S_DONE) && r_op_wr && w_io;
  assign Busy     = (r_state != S_IDLE);
  assign OutPort  = r_outport;
  assign ReqError = r_reqerr;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (default parameters, LATENCY=2).
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_mem_responder;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        MemRead, MemWrite;
  logic [7:0]  Addr;
  logic [15:0] WriteData;
  logic [15:0] ReadData;
  logic        MemReady, Busy, OutValid, ReqError;
  logic [15:0] OutPort;

  int nchk = 0;
  int nerr = 0;
  logic [15:0] snap_ff;
  int rdy_seen;

  mem_responder dut (
    .CLK(CLK), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
    .MemReady(MemReady), .Busy(Busy), .OutPort(OutPort),
    .OutValid(OutValid), .ReqError(ReqError)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a request and take edge 0 (accept).
  task automatic req_start(input logic wr, input logic [7:0] a, input logic [15:0] d);
    MemRead = ~wr; MemWrite = wr; Addr = a; WriteData = d;
    tick();
    chk("busy_after_accept", Busy, 1);
    chk("rdy_edge0", MemReady, 0);
  endtask

  // Edges 1 and 2: MemReady must appear only after edge 2.
  task automatic req_wait();
    tick();
    chk("rdy_edge1", MemReady, 0);
    tick();
    chk("rdy_edge2", MemReady, 1);
  endtask

  // Drop request; one cycle in RELEASE, then IDLE.
  task automatic req_release();
    MemRead = 0; MemWrite = 0;
    tick();
    chk("rdy_one_cycle", MemReady, 0);
    chk("busy_release", Busy, 1);
    tick();
    chk("busy_idle", Busy, 0);
  endtask

  initial begin
    Reset = 0; MemRead = 0; MemWrite = 0; Addr = 0; WriteData = 0;
    #12;
    chk("rst_rdata", ReadData, 0);
    chk("rst_rdy", MemReady, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_outport", OutPort, 0);
    chk("rst_outvalid", OutValid, 0);
    chk("rst_reqerr", ReqError, 0);
    tick();
    Reset = 1;
    tick();
    chk("idle_busy", Busy, 0);

    // Write 0x10 <- BEEF
    req_start(1, 8'h10, 16'hBEEF);
    req_wait();
    chk("wr_ram_outvalid", OutValid, 0);
    req_release();

    // Read 0x10, hold MemRead 5 extra cycles
    req_start(0, 8'h10, 16'h0);
    req_wait();
    chk("rd_10", ReadData, 16'hBEEF);
    rdy_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (MemReady) rdy_seen++;
      chk("hold_busy", Busy, 1);
    end
    chk("hold_no_second_rdy", rdy_seen, 0);
    MemRead = 0;
    tick();
    chk("drop_busy", Busy, 0);

    // Write to IO address
    snap_ff = dut.r_mem[8'hFF];
    req_start(1, 8'hFF, 16'h0042);
    req_wait();
    chk("io_outport", OutPort, 16'h0042);
    chk("io_outvalid", OutValid, 1);
    chk("io_rdata_kept", ReadData, 16'hBEEF);
    req_release();
    chk("io_outvalid_pulse", OutValid, 0);
    chk("io_ram_untouched", dut.r_mem[8'hFF], snap_ff);

    // Read IO address
    req_start(0, 8'hFF, 16'h0);
    req_wait();
    chk("rd_io", ReadData, 16'h0042);
    req_release();

    // Both requests high in IDLE
    MemRead = 1; MemWrite = 1; Addr = 8'h10;
    tick();
    chk("both_reqerr", ReqError, 1);
    chk("both_busy", Busy, 0);
    chk("both_rdy", MemReady, 0);
    tick();
    chk("both_busy2", Busy, 0);
    MemRead = 0; MemWrite = 0;
    tick();

    // Address change during WAIT is ignored
    req_start(1, 8'h20, 16'h5555);
    req_wait();
    req_release();
    req_start(0, 8'h10, 16'h0);
    Addr = 8'h20;
    req_wait();
    chk("latched_addr", ReadData, 16'hBEEF);
    chk("reqerr_sticky", ReqError, 1);
    req_release();

    // Reset during WAIT of a write abandons it
    req_start(1, 8'h30, 16'h1111);
    req_wait();
    req_release();
    req_start(1, 8'h30, 16'h2222);
    Reset = 0; MemWrite = 0;
    #1;
    chk("mid_rst_busy", Busy, 0);
    chk("mid_rst_rdy", MemReady, 0);
    chk("mid_rst_rdata", ReadData, 0);
    chk("mid_rst_outport", OutPort, 0);
    chk("mid_rst_reqerr", ReqError, 0);
    tick();
    tick();
    Reset = 1;
    rdy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (MemReady) rdy_seen++;
    end
    chk("abandon_no_rdy", rdy_seen, 0);
    req_start(0, 8'h30, 16'h0);
    req_wait();
    chk("abandon_ram", ReadData, 16'h1111);
    req_release();
    req_start(0, 8'h10, 16'h0);
    req_wait();
    chk("ram_survives_reset", ReadData, 16'hBEEF);
    req_release();

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle control unit's MemRead/MemWrite strobes.
- Owns a word-addressed data RAM and one memory-mapped output register that implements the OutputWrite path.
- Answers each request after a fixed, parameterised latency with a one-cycle MemReady pulse.
- Sits between the datapath's address/write-data registers and the control unit's memory-access states.

Parameters:
- DATA_W, 16, word width.
- ADDR_W, 8, address width; RAM depth is 2^ADDR_W words.
- LATENCY, 2, cycles from request accept to MemReady; legal range 1..15.
- IO_ADDR, 8'hFF, address decoded as the output register instead of RAM.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset (Reset=0 resets).
- MemRead  in  1  read request level from control unit.
- MemWrite  in  1  write request level from control unit.
- Addr  in  ADDR_W  word address.
- WriteData  in  DATA_W  store data.
- ReadData  out  DATA_W  load data; valid when MemReady=1, held afterwards.
- MemReady  out  1  one-cycle completion pulse.
- Busy  out  1  high whenever the FSM is not in IDLE.
- OutPort  out  DATA_W  memory-mapped output register.
- OutValid  out  1  one-cycle pulse when OutPort is written.
- ReqError  out  1  sticky flag: MemRead and MemWrite were both seen high while in IDLE.

Behaviour:
- Reset (async, Reset=0):
  - State goes to IDLE and the counter clears.
  - ReadData=0, MemReady=0, OutPort=0, OutValid=0, ReqError=0; Busy=0 follows from IDLE.
  - RAM contents are not cleared and survive reset.
  - Reset mid-transaction abandons it: no RAM write, no MemReady.
- FSM states: IDLE, WAIT, DONE, RELEASE.
- IDLE:
  - On an edge with exactly one of MemRead/MemWrite high, latch op, Addr and WriteData, load cnt=LATENCY-1, go to WAIT.
  - Both requests high: set ReqError (sticky until reset), stay in IDLE, no access.
  - Neither high: stay in IDLE.
- WAIT:
  - cnt==0: go to DONE, performing the access on the same edge. A read loads ReadData from RAM[addr] or from OutPort if addr==IO_ADDR. A write stores to RAM[addr], or to OutPort if addr==IO_ADDR.
  - Otherwise cnt decrements.
  - Input changes in WAIT are ignored; the latched values are used.
- DONE:
  - MemReady=1 for exactly this cycle.
  - OutValid=1 this cycle only if the transaction was a write to IO_ADDR.
  - Next edge goes to RELEASE.
- RELEASE:
  - Stays until both MemRead and MemWrite are low, then IDLE.
  - Guarantees one request level produces exactly one transaction.
  - Minimum gap between transactions is one IDLE-eligible edge after release.
- Latency:
  - Accept edge = edge 0; DONE is entered on edge LATENCY.
  - MemReady is high in the cycle after edge LATENCY.
  - LATENCY=1 still passes through WAIT for one cycle.
- ReadData:
  - Changes only on read completion.
  - Writes do not disturb it.
- Writes to IO_ADDR never touch RAM[IO_ADDR].
- Busy = (state != IDLE), combinational from state.
- Simultaneous events:
  - A request arriving in DONE or RELEASE is not accepted until IDLE.
  - A request held continuously through RELEASE is not re-accepted; it must drop first.

Test Plan:
- Reset release, then write Addr=8'h10, WriteData=16'hBEEF, LATENCY=2 -> Busy=1 from edge 0; MemReady=1 exactly one cycle after edge 2; RAM[8'h10]=16'hBEEF.
- Read Addr=8'h10 -> MemReady after edge 2 with ReadData=16'hBEEF. Hold MemRead high for 5 more cycles -> no second MemReady. Drop MemRead -> Busy=0 next edge.
- Write Addr=8'hFF, WriteData=16'h0042 -> OutPort=16'h0042 and OutValid=1 for one cycle; RAM[8'hFF] unchanged. A following read of 8'hFF returns 16'h0042.
- MemRead=MemWrite=1 in IDLE -> ReqError=1, Busy stays 0, no MemReady. Subsequent normal reads still complete; ReqError remains 1 until Reset=0.
- Change Addr to 8'h20 during WAIT of a read of 8'h10 -> ReadData = RAM[8'h10].
- Assert Reset=0 while in WAIT of a write of 8'h30 -> outputs zero immediately, RAM[8'h30] unchanged, no MemReady after release.
